hex_display_ctrl: RTL and testbench
===================================

# hex_display_ctrl

- Sequencer for the four-digit HEX_display decoder in the bit error tester.
- Selects one of four 16-bit status words (e.g. bit count, error count, error rate, pattern ID) as the display page.
  - The page advances on a debounced push-button press, and optionally on an auto-scroll timer.
- Samples the selected word at a fixed refresh rate into a held register that drives HEX_display `data`, so digits do not flicker while counters run.

## Interface

**Parameters**

- `REFRESH_DIV`, default 5_000_000: clk cycles per display refresh tick (10 Hz at 50 MHz); legal range ≥2.
- `DEBOUNCE_CYC`, default 500_000: stable cycles required to accept a button level change; legal range ≥2.
- `SCROLL_DIV`, default 100_000_000: clk cycles per auto-scroll advance; used only with `AUTO_SCROLL_EN`; legal range ≥2.

**Ports**

- `clk` in 1: single system clock.
- `reset` in 1: asynchronous, active-high reset.
- `btn_next` in 1: raw, asynchronous push-button level, active-high.
- `hold` in 1: synchronous, 1 = freeze `data_out`.
- `src0`..`src3` in 16 each: status words, synchronous to `clk`.
- `data_out` out 16: held word, connects to HEX_display `data`.
- `page` out 2: index of the currently selected source.
- `update` out 1: one-cycle pulse in the cycle after `data_out` was loaded.

## Operation

**Button path**
- `btn_next` passes through a 2-FF synchronizer, `s1` then `s2`.
- Debounce counter:
  - Increments each cycle that `s2 != stable`.
  - Clears to 0 when `s2 == stable`.
  - When the counter equals `DEBOUNCE_CYC-1` and `s2 != stable`: `stable <= s2`, counter `<= 0`.
- `press = stable & ~stable_d` (combinational; `stable_d` is a registered copy of `stable`).
- Release edges generate no event.
- A glitch shorter than `DEBOUNCE_CYC` cycles generates no event.

**Page advance**
- Advance event = `press`, or (with macro) the scroll terminal count.
- On an advance event: `page <= page+1`; 3 wraps to 0.
- A press and a scroll terminal in the same cycle produce a single advance.

**Refresh**
- Prescaler counts 0..`REFRESH_DIV-1`, then wraps; `tick` = (count == `REFRESH_DIV-1`).
- `force` flag is set by any advance event and cleared on the next edge.
- Load condition = `(tick | force) & ~hold`.
- On load: `data_out <= src[page]` using the current `page` register, then `update <= 1`.
- On a `force` load the prescaler restarts at 0.
- `hold=1`:
  - Blocks all loads; a `force` occurring during hold is discarded.
  - `page` still advances.
  - After `hold` falls, the next `tick` loads.
- Tick and advance in the same cycle: the tick loads the old page's word; the force load of the new page follows one cycle later.

**Reset (asynchronous, while high)**
- `data_out=0x0000`, `page=0`, `update=0`.
- All counters, `s1`, `s2`, `stable`, `stable_d`, `force` = 0.
- Reset mid-debounce or mid-scroll discards the pending event.

## Timing

- Edge 1 = first rising edge that samples `btn_next=1`, held high throughout.
  - `stable` rises at edge 2+`DEBOUNCE_CYC`.
  - `page` increments at edge 3+`DEBOUNCE_CYC`.
  - `data_out` loads at edge 4+`DEBOUNCE_CYC`; `update` is high for that one cycle.
- Tick-driven load: `data_out` changes on the edge at which the prescaler wraps; `update` is high for the following cycle.
- Refresh period: exactly `REFRESH_DIV` cycles between ticks absent a force restart.
- `src*` are sampled only at the load edge; no other input-to-output path exists.
- All outputs are registered.

## Configuration

- `HEX_DISPLAY_CTRL_AUTO_SCROLL_EN` defined:
  - Scroll counter counts 0..`SCROLL_DIV-1`; its terminal count is an advance event.
  - Any `press` clears the scroll counter to 0.
  - `hold=1` stalls the scroll counter at its current value.
- Macro undefined:
  - No scroll counter is built; `SCROLL_DIV` is ignored.
  - `page` changes only on `press`.

## Test plan

Bench parameters: `REFRESH_DIV=8`, `DEBOUNCE_CYC=4`, `SCROLL_DIV=32`. Sources: `src0=0x1111`, `src1=0x2222`, `src2=0x3333`, `src3=0xABCD`.

- **Reset:** assert `reset` mid-count, release → `data_out=0x0000`, `page=0`, `update=0`; first tick 8 cycles later loads `0x1111` with `update` pulse.
- **Debounce:** 3-cycle `btn_next` glitch → `page` stays 0. Held press → `page=1` at edge 7; `data_out=0x2222` at edge 8; `update` high one cycle.
- **Wrap:** four clean presses → `page` sequence 1, 2, 3, 0; `data_out` sequence `0x2222`, `0x3333`, `0xABCD`, `0x1111`.
- **Hold:** `hold=1`, change `src0` to `0x5555`, then press → `page=1`, `data_out` unchanged, no `update`. Drop `hold` → next tick loads `0x2222`.
- **Collision:** press event coincident with tick → tick loads old page's word; next cycle loads new page's word; two `update` pulses.
- **With `HEX_DISPLAY_CTRL_AUTO_SCROLL_EN`:** idle 32 cycles → `page` 0→1 plus force load. Press at scroll count 20 → one advance; next auto advance 32 cycles after the press.

Source files
------------

// File: rtl/hex_display_ctrl.sv
// Page sequencer and refresh-rate sampler that feeds the four-digit HEX display.
// Defining HEX_DISPLAY_CTRL_AUTO_SCROLL_EN adds an auto-scroll page timer.
module hex_display_ctrl #(
   parameter int REFRESH_DIV  = 5_000_000,
   parameter int DEBOUNCE_CYC = 500_000,
   parameter int SCROLL_DIV   = 100_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_next,
   input  logic        hold,
   input  logic [15:0] src0,
   input  logic [15:0] src1,
   input  logic [15:0] src2,
   input  logic [15:0] src3,
   output logic [15:0] data_out,
   output logic [1:0]  page,
   output logic        update
);

   localparam int REF_W = $clog2(REFRESH_DIV);
   localparam int DB_W  = $clog2(DEBOUNCE_CYC);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);

   if (REFRESH_DIV < 2) begin : g_bad_refresh_div
      $error("REFRESH_DIV must be at least 2");
   end
   if (DEBOUNCE_CYC < 2) begin : g_bad_debounce_cyc
      $error("DEBOUNCE_CYC must be at least 2");
   end
   if (SCROLL_DIV < 2) begin : g_bad_scroll_div
      $error("SCROLL_DIV must be at least 2");
   end

   logic             s1;
   logic             s2;
   logic             stable;
   logic             stable_d;
   logic             press;
   logic [DB_W-1:0]  db_cnt;
   logic             advance;
   logic             force_load;
   logic [REF_W-1:0] ref_cnt;
   logic             tick;
   logic             load;
   logic [15:0]      sel_word;

   // The button is fully asynchronous, so it gets two flops before any logic sees it.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn_next;
         s2 <= s1;
      end
   end

   // A level change is accepted only after DEBOUNCE_CYC consecutive differing samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_cnt   <= '0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
      end else begin
         stable_d <= stable;
         if (s2 == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            stable <= s2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign press = stable & ~stable_d;

`ifdef HEX_DISPLAY_CTRL_AUTO_SCROLL_EN
   localparam int SC_W = $clog2(SCROLL_DIV);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCROLL_DIV - 1);

   logic [SC_W-1:0] sc_cnt;
   logic            scroll_adv;

   // Hold stalls the timer, so a terminal count reached under hold waits for release.
   assign scroll_adv = (sc_cnt == SC_LAST) & ~hold;
   assign advance    = press | scroll_adv;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sc_cnt <= '0;
      end else if (press) begin
         sc_cnt <= '0;
      end else if (!hold) begin
         if (sc_cnt == SC_LAST) begin
            sc_cnt <= '0;
         end else begin
            sc_cnt <= sc_cnt + 1'b1;
         end
      end
   end
`else
   assign advance = press;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         page       <= 2'd0;
         force_load <= 1'b0;
      end else begin
         force_load <= advance;
         if (advance) begin
            page <= page + 2'd1;
         end
      end
   end

   assign tick = (ref_cnt == REF_LAST);
   assign load = (tick | force_load) & ~hold;

   // A forced load restarts the refresh period; a forced load under hold is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_cnt <= '0;
      end else if (tick | (force_load & ~hold)) begin
         ref_cnt <= '0;
      end else begin
         ref_cnt <= ref_cnt + 1'b1;
      end
   end

   // NOTE: default assignment first so no path through the block can infer a latch.
   always_comb begin
      sel_word = src0;
      case (page)
         2'd0: sel_word = src0;
         2'd1: sel_word = src1;
         2'd2: sel_word = src2;
         2'd3: sel_word = src3;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out <= 16'h0000;
         update   <= 1'b0;
      end else begin
         update <= load;
         if (load) begin
            data_out <= sel_word;
         end
      end
   end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed plus randomized bench for hex_display_ctrl against a timestamp-based reference model.
// Scroll checks are included when HEX_DISPLAY_CTRL_AUTO_SCROLL_EN is defined.
module tb_hex_display_ctrl;

   localparam int R = 8;
   localparam int D = 4;
   localparam int S = 32;

   logic        clk      = 1'b0;
   logic        reset    = 1'b0;
   logic        btn_next = 1'b0;
   logic        hold     = 1'b0;
   logic [15:0] src [4];
   logic [15:0] data_out;
   logic [1:0]  page;
   logic        update;

   int n_checks = 0;
   int n_pass   = 0;

   hex_display_ctrl #(
      .REFRESH_DIV  (R),
      .DEBOUNCE_CYC (D),
      .SCROLL_DIV   (S)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_next (btn_next),
      .hold     (hold),
      .src0     (src[0]),
      .src1     (src[1]),
      .src2     (src[2]),
      .src3     (src[3]),
      .data_out (data_out),
      .page     (page),
      .update   (update)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Reference model: edge counter with a refresh time base, button sample history,
   // and the accepted button level.
   logic [15:0] data_m;
   logic [1:0]  page_m;
   logic        upd_m;
   bit          lvl;
   bit          press_pend;
   bit          adv_prev;
   bit          hist [D+1];
   int          e_cnt;
   int          base;
`ifdef HEX_DISPLAY_CTRL_AUTO_SCROLL_EN
   int          active;
`endif

   task automatic model_reset();
      data_m     = 16'h0000;
      page_m     = 2'd0;
      upd_m      = 1'b0;
      lvl        = 1'b0;
      press_pend = 1'b0;
      adv_prev   = 1'b0;
      e_cnt      = 0;
      base       = 0;
`ifdef HEX_DISPLAY_CTRL_AUTO_SCROLL_EN
      active     = 0;
`endif
      for (int i = 0; i <= D; i++) hist[i] = 1'b0;
   endtask

   task automatic model_edge();
      bit tick;
      bit frc;
      bit ld;
      bit adv;
      bit all_flip;
      e_cnt++;
      tick = ((e_cnt - base) % R) == 0;
      frc  = adv_prev;
      ld   = (tick || frc) && !hold;
      if (ld) data_m = src[page_m];
      upd_m = ld;
      if (frc && !hold) base = e_cnt;
      adv = press_pend;
`ifdef HEX_DISPLAY_CTRL_AUTO_SCROLL_EN
      if (press_pend) begin
         active = 0;
      end else if (!hold) begin
         active++;
         if (active % S == 0) adv = 1'b1;
      end
`endif
      if (adv) page_m = page_m + 2'd1;
      adv_prev = adv;
      all_flip = 1'b1;
      for (int i = 0; i < D; i++) if (hist[i] == lvl) all_flip = 1'b0;
      press_pend = all_flip && !lvl;
      if (all_flip) lvl = !lvl;
      for (int i = 0; i < D; i++) hist[i] = hist[i+1];
      hist[D] = btn_next;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         if (reset) model_reset();
         else       model_edge();
         @(negedge clk);
         check("data_out", data_out, data_m);
         check("page", {14'd0, page}, {14'd0, page_m});
         check("update", {15'd0, update}, {15'd0, upd_m});
      end
   endtask

   task automatic wait_page_change(input logic [1:0] old);
      int n = 0;
      while (page == old && n < 20) begin
         step(1);
         n++;
      end
      check("page_change_seen", {15'd0, page != old}, 16'd1);
   endtask

   initial begin
      logic [1:0]  p_old;
      logic [1:0]  wrap_pg  [3];
      logic [15:0] wrap_dat [3];
      int          n;

      wrap_pg  = '{2'd2, 2'd3, 2'd0};
      wrap_dat = '{16'h3333, 16'hABCD, 16'h1111};
      src[0] = 16'h1111;
      src[1] = 16'h2222;
      src[2] = 16'h3333;
      src[3] = 16'hABCD;

      #1 reset = 1'b1;
      model_reset();
      step(2);
      reset = 1'b0;
      step(12);

      // Reset in mid-count clears everything immediately.
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_data", data_out, 16'h0000);
      check("rst_page", {14'd0, page}, 16'd0);
      check("rst_update", {15'd0, update}, 16'd0);
      step(2);
      reset = 1'b0;
      step(7);
      check("pre_tick_data", data_out, 16'h0000);
      step(1);
      check("first_tick_data", data_out, 16'h1111);
      check("first_tick_update", {15'd0, update}, 16'd1);

      // Short glitch is filtered out.
      btn_next = 1'b1;
      step(3);
      btn_next = 1'b0;
      step(10);
      check("glitch_page", {14'd0, page}, 16'd0);

      // Held press: page at edge 7, data at edge 8, single update pulse.
      btn_next = 1'b1;
      step(6);
      check("press_e6_page", {14'd0, page}, 16'd0);
      step(1);
      check("press_e7_page", {14'd0, page}, 16'd1);
      step(1);
      check("press_e8_data", data_out, 16'h2222);
      check("press_e8_update", {15'd0, update}, 16'd1);
      step(1);
      check("press_e9_update", {15'd0, update}, 16'd0);
      btn_next = 1'b0;
      step(8);

      // Remaining presses of the wrap sequence.
      for (int k = 0; k < 3; k++) begin
         p_old = page;
         btn_next = 1'b1;
         wait_page_change(p_old);
         step(1);
`ifndef HEX_DISPLAY_CTRL_AUTO_SCROLL_EN
         check("wrap_page", {14'd0, page}, {14'd0, wrap_pg[k]});
         check("wrap_data", data_out, wrap_dat[k]);
`endif
         btn_next = 1'b0;
         step(8);
      end

      // Hold freezes data_out while page still advances.
      hold = 1'b1;
      src[0] = 16'h5555;
      p_old = page;
      btn_next = 1'b1;
      wait_page_change(p_old);
      step(1);
`ifndef HEX_DISPLAY_CTRL_AUTO_SCROLL_EN
      check("hold_page", {14'd0, page}, 16'd1);
      check("hold_data", data_out, 16'h1111);
`endif
      btn_next = 1'b0;
      step(8);
      hold = 1'b0;
      n = 0;
      while (update !== 1'b1 && n < R + 2) begin
         step(1);
         n++;
      end
      check("hold_release_update", {15'd0, update}, 16'd1);
`ifndef HEX_DISPLAY_CTRL_AUTO_SCROLL_EN
      check("hold_release_data", data_out, 16'h2222);
`endif
      src[0] = 16'h1111;
      step(4);

      // Press advance lands on a tick two periods after a forced load.
      p_old = page;
      btn_next = 1'b1;
      wait_page_change(p_old);
      step(1);
      p_old = page;
      btn_next = 1'b0;
      step(9);
      btn_next = 1'b1;
      step(7);
`ifndef HEX_DISPLAY_CTRL_AUTO_SCROLL_EN
      check("coll_tick_update", {15'd0, update}, 16'd1);
      check("coll_tick_data", data_out, src[p_old]);
      check("coll_tick_page", {14'd0, page}, {14'd0, p_old + 2'd1});
`endif
      step(1);
`ifndef HEX_DISPLAY_CTRL_AUTO_SCROLL_EN
      check("coll_force_update", {15'd0, update}, 16'd1);
      check("coll_force_data", data_out, src[p_old + 2'd1]);
`endif
      step(1);
`ifndef HEX_DISPLAY_CTRL_AUTO_SCROLL_EN
      check("coll_after_update", {15'd0, update}, 16'd0);
`endif
      btn_next = 1'b0;
      step(8);

      // Randomized traffic against the model.
      for (int it = 0; it < 150; it++) begin
         btn_next = 1'($urandom_range(0, 1));
         hold     = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 3) == 0) src[$urandom_range(0, 3)] = 16'($urandom);
         step($urandom_range(1, 12));
      end
      btn_next = 1'b0;
      hold     = 1'b0;
      step(80);

`ifdef HEX_DISPLAY_CTRL_AUTO_SCROLL_EN
      src[0] = 16'h1111;
      src[1] = 16'h2222;
      src[2] = 16'h3333;
      src[3] = 16'hABCD;
      reset = 1'b1;
      model_reset();
      step(2);
      reset = 1'b0;
      step(31);
      check("scroll_e31_page", {14'd0, page}, 16'd0);
      step(1);
      check("scroll_e32_page", {14'd0, page}, 16'd1);
      step(1);
      check("scroll_force_data", data_out, 16'h2222);
      check("scroll_force_update", {15'd0, update}, 16'd1);
      step(13);
      btn_next = 1'b1;
      wait_page_change(2'd1);
      check("scroll_press_page", {14'd0, page}, 16'd2);
      btn_next = 1'b0;
      step(31);
      check("scroll_wait_page", {14'd0, page}, 16'd2);
      step(1);
      check("scroll_next_page", {14'd0, page}, 16'd3);
      step(4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
